alu_wb_seq: RTL



---
 rtl/alu_wb_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_wb_seq.sv
// ----------------------------------------------------------------------------
// alu_wb_seq
//
// Write-back sequencer sitting directly after the main ALU. It takes one ALU
// result at a time through a valid/ready handshake. It then drives the single
// register-file write port:
//   - narrow ops write r to the destination register;
//   - wide ops (MUL/DIV) write r to the destination, then s to HI_REG on the
//     next cycle;
//   - an ALU overflow turns into a held exception request and writes nothing.
//
// Optional build macro:
//   ALU_WB_PIPE_EN  - when defined, a new narrow result can be accepted while
//                     the previous narrow result is being written (WR_LO).
//                     This gives back-to-back writes at 1 op/cycle. When it is
//                     undefined, results are accepted only from IDLE.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   ALU result valid
//   in_ready  out  sequencer can accept a result this cycle
//   alu_r     in   ALU lower result        [REG_DATA_WIDTH]
//   alu_s     in   ALU upper result        [REG_DATA_WIDTH]
//   alu_exc   in   ALU overflow flag
//   dest_reg  in   destination register    [REG_ADDR_WIDTH]
//   wide      in   op writes both halves (MUL/DIV)
//   flush     in   synchronous abort of any pending write
//   rf_we     out  register-file write enable
//   rf_waddr  out  register-file write address [REG_ADDR_WIDTH]
//   rf_wdata  out  register-file write data    [REG_DATA_WIDTH]
//   exc_req   out  exception request, held until exc_ack
//   exc_ack   in   control acknowledges the exception
// ----------------------------------------------------------------------------
module alu_wb_seq #(
    parameter int REG_DATA_WIDTH = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int HI_REG         = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_DATA_WIDTH-1:0] alu_r,
    input  logic [REG_DATA_WIDTH-1:0] alu_s,
    input  logic                      alu_exc,
    input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
    input  logic                      wide,
    input  logic                      flush,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [REG_DATA_WIDTH-1:0] rf_wdata,
    output logic                      exc_req,
    input  logic                      exc_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2,
        EXC   = 2'd3
    } state_t;

    localparam logic [REG_ADDR_WIDTH-1:0] HI_ADDR = REG_ADDR_WIDTH'(HI_REG);

    state_t                    state;
    logic [REG_DATA_WIDTH-1:0] cap_s;
    logic                      cap_wide;
    logic                      accept;

    // Ready decode. A flush in the same cycle always blocks an accept. in_ready
    // is also gated with rst_n so that it reads 0 while reset is held.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n && !flush) begin
            if (state == IDLE) begin
                in_ready = 1'b1;
            end
`ifdef ALU_WB_PIPE_EN
            else if (state == WR_LO && !cap_wide) begin
                in_ready = 1'b1;
            end
`endif
        end
    end

    assign accept = in_valid & in_ready;

    // Sequencer state and registered outputs.
    //
    // On accept, the lower half and the destination go straight into
    // rf_wdata/rf_waddr, because the WR_LO write is presented on the cycle
    // right after the accept. The overflow flag is held by the EXC state.
    // Only the upper half and the wide flag need separate capture registers,
    // because WR_HI uses them one cycle later.
    //
    // rf_we defaults low on every edge, so each write is a single-cycle
    // pulse. A flush therefore lets the write already on the port complete,
    // but no further write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cap_s    <= '0;
            cap_wide <= 1'b0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            exc_req  <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            if (flush) begin
                state   <= IDLE;
                exc_req <= 1'b0;
            end else if (accept) begin
                cap_s    <= alu_s;
                cap_wide <= wide;
                rf_waddr <= dest_reg;
                rf_wdata <= alu_r;
                if (alu_exc) begin
                    state   <= EXC;
                    exc_req <= 1'b1;
                end else begin
                    state <= WR_LO;
                    // R0 is hard-wired to zero, so its write is dropped here.
                    // The state sequence is still the same.
                    rf_we <= (dest_reg != '0);
                end
            end else begin
                case (state)
                    WR_LO: begin
                        if (cap_wide) begin
                            state    <= WR_HI;
                            rf_we    <= 1'b1;
                            rf_waddr <= HI_ADDR;
                            rf_wdata <= cap_s;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    WR_HI: begin
                        state <= IDLE;
                    end
                    EXC: begin
                        if (exc_ack) begin
                            exc_req <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
